// File: rtl/sap_ram_if.sv
// Bus-side signal bundle for the SAP program/data RAM: CPU read path plus
// the front-panel programming handshake.
interface sap_ram_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic [AW-1:0] addr;
    logic          ce;
    logic [DW-1:0] bus;
    logic          prog;
    logic [DW-1:0] pdata;
    logic          pvalid;
    logic          pready;
    logic          pdone;

    modport master (
        output addr, ce, prog, pdata, pvalid,
        input  bus, pready, pdone
    );

    modport slave (
        input  addr, ce, prog, pdata, pvalid,
        output bus, pready, pdone
    );
endinterface

// File: rtl/sap_ram.sv
// SAP program/data RAM: registered one-cycle read onto the shared bus in RUN,
// sequential fill from a valid/ready programming stream in PROG.
module sap_ram #(
    parameter int AW    = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 2**AW
) (
    input logic    clk,
    input logic    clr,
    sap_ram_if.slave m
);
    typedef enum logic [1:0] {RUN, PROG, FULL} state_t;

    state_t        state, state_nx;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata;
    logic [AW-1:0] pptr;
    logic          pdone_q;
    logic          xfer;
    logic          last;

    assign xfer = m.pvalid && (state == PROG);
    assign last = (pptr == AW'(DEPTH - 1));

    // NOTE: every signal assigned here gets its default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        unique case (state)
            RUN:  if (m.prog) state_nx = PROG;
            PROG: begin
                if (!m.prog)          state_nx = RUN;
                else if (xfer && last) state_nx = FULL;
            end
            FULL: if (!m.prog) state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= RUN;
            pptr    <= '0;
            pdone_q <= 1'b0;
        end else begin
            state   <= state_nx;
            pdone_q <= (state_nx == FULL);
            if (state == RUN && m.prog) pptr <= '0;
            else if (xfer)              pptr <= pptr + 1'b1;
        end
    end

    // NOTE: the array sits in the async-reset block on purpose: a reset must
    // wipe any partially loaded program, so this maps to flops, not a RAM macro.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rdata <= '0;
        end else begin
            if (xfer)         mem[pptr] <= m.pdata;
            if (state == RUN) rdata     <= mem[m.addr];
        end
    end

    assign m.pready = (state == PROG);
    assign m.pdone  = pdone_q;
    assign m.bus    = (state == RUN && !m.ce) ? rdata : '0;
endmodule

// File: tb/tb_sap_ram.sv
// Randomized self-checking bench for sap_ram: behavioural RAM model, per-cycle
// compare on the falling edge, plus literal expectations from the test plan.
module tb_sap_ram;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   checks = 0;
    int   errors = 0;

    sap_ram_if #(.AW(AW), .DW(DW)) bi ();

    sap_ram #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .clr (clr),
        .m   (bi.slave)
    );

    always #5 clk = ~clk;

    // Behavioural model: memory array, read register, session pointer and
    // two mode flags (programming session open, session completed).
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_rdata;
    int            m_ptr;
    bit            m_inprog;
    bit            m_full;

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            foreach (m_mem[i]) m_mem[i] <= '0;
            m_rdata  <= '0;
            m_ptr    <= 0;
            m_inprog <= 1'b0;
            m_full   <= 1'b0;
        end else if (m_full) begin
            if (!bi.prog) m_full <= 1'b0;
        end else if (m_inprog) begin
            if (bi.pvalid) begin
                m_mem[m_ptr] <= bi.pdata;
                m_ptr        <= m_ptr + 1;
            end
            if (!bi.prog) m_inprog <= 1'b0;
            else if (bi.pvalid && m_ptr == DEPTH - 1) begin
                m_inprog <= 1'b0;
                m_full   <= 1'b1;
            end
        end else begin
            m_rdata <= m_mem[bi.addr];
            if (bi.prog) begin
                m_inprog <= 1'b1;
                m_ptr    <= 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_bus();
        return (!m_inprog && !m_full && !bi.ce) ? m_rdata : '0;
    endfunction

    always @(negedge clk) begin
        if (clr) begin
            check("cmp_bus",    32'(bi.bus),    32'(exp_bus()));
            check("cmp_pready", 32'(bi.pready), 32'(m_inprog));
            check("cmp_pdone",  32'(bi.pdone),  32'(m_full));
        end
    end

    // Inputs change 1 time unit after the rising edge, well clear of both edges.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_bus(input string name, input logic [DW-1:0] exp);
        @(negedge clk);
        check(name, 32'(bi.bus), 32'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bi.addr = 4'h5; bi.ce = 1'b0; bi.prog = 1'b0;
        bi.pdata = '0;  bi.pvalid = 1'b0;
        #12 clr = 1'b1;

        // 1: reset then RUN read of address 5.
        cyc();
        @(negedge clk);
        check("t1_bus",    32'(bi.bus),    32'h00);
        check("t1_pready", 32'(bi.pready), 32'h0);
        check("t1_pdone",  32'(bi.pdone),  32'h0);

        // 2: stream 16 words back to back.
        bi.prog = 1'b1;
        cyc();
        for (int i = 0; i < DEPTH; i++) begin
            bi.pdata  = 8'(8'h10 + i);
            bi.pvalid = 1'b1;
            cyc();
        end
        bi.pvalid = 1'b0;
        @(negedge clk);
        check("t2_pdone",  32'(bi.pdone),  32'h1);
        check("t2_pready", 32'(bi.pready), 32'h0);
        check("t2_bus",    32'(bi.bus),    32'h00);

        // 3: back to RUN and read.
        bi.prog = 1'b0;
        cyc();
        bi.ce = 1'b0; bi.addr = 4'h3;
        cyc();
        expect_bus("t3_addr3", 8'h13);
        cyc();
        bi.addr = 4'hF;
        cyc();
        expect_bus("t3_addrF", 8'h1F);
        cyc();
        bi.ce = 1'b1;
        #1 check("t3_ce_off", 32'(bi.bus), 32'h00);

        // 4: partial session with pvalid toggling, aborted by prog=0.
        bi.prog = 1'b1;
        cyc();
        for (int k = 0; k < 10; k++) begin
            bi.pvalid = (k % 2 == 0);
            bi.pdata  = bi.pvalid ? 8'(8'hA0 + k / 2) : 8'($urandom);
            cyc();
        end
        bi.pvalid = 1'b0; bi.prog = 1'b0;
        cyc();
        bi.ce = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bi.addr = 4'(i);
            cyc();
            expect_bus($sformatf("t4_mem%0d", i), (i < 5) ? 8'(8'hA0 + i) : 8'(8'h10 + i));
            cyc();
        end

        // 5: async reset in the middle of a session.
        bi.prog = 1'b1;
        cyc();
        for (int k = 0; k < 3; k++) begin
            bi.pvalid = 1'b1; bi.pdata = 8'($urandom);
            cyc();
        end
        bi.pvalid = 1'b0;
        #1 check("t5_pready_pre", 32'(bi.pready), 32'h1);
        clr = 1'b0;
        #1;
        check("t5_pready", 32'(bi.pready), 32'h0);
        check("t5_pdone",  32'(bi.pdone),  32'h0);
        check("t5_bus",    32'(bi.bus),    32'h00);
        bi.prog = 1'b0;
        #1 clr = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            bi.addr = 4'(i);
            cyc();
            expect_bus($sformatf("t5_clr%0d", i), 8'h00);
            cyc();
        end

        // 6: random full load, then back-to-back reads 2,7,2.
        bi.prog = 1'b1;
        cyc();
        while (!bi.pdone) begin
            bi.pvalid = 1'($urandom_range(0, 1));
            bi.pdata  = 8'($urandom);
            cyc();
        end
        bi.pvalid = 1'b0; bi.prog = 1'b0;
        cyc();
        bi.ce = 1'b0; bi.addr = 4'd2;
        cyc();
        @(negedge clk) check("t6_rd2a", 32'(bi.bus), 32'(m_mem[2]));
        bi.addr = 4'd7;
        cyc();
        @(negedge clk) check("t6_rd7", 32'(bi.bus), 32'(m_mem[7]));
        bi.addr = 4'd2;
        cyc();
        @(negedge clk) check("t6_rd2b", 32'(bi.bus), 32'(m_mem[2]));
        cyc();

        // Random phase: long-lived prog, noisy handshake, occasional resets.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 39) == 0) bi.prog = ~bi.prog;
            bi.pvalid = 1'($urandom_range(0, 1));
            bi.pdata  = 8'($urandom);
            bi.addr   = 4'($urandom);
            bi.ce     = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 399) == 0) begin
                clr = 1'b0;
                #2 clr = 1'b1;
            end
            cyc();
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sap_ram.md
Name: sap_ram

Overview:
- Program/data RAM at the far end of the memory-address-register path in the SAP-style CPU.
- Takes the 4-bit address held by the MAR and returns the addressed word onto the shared bus when enabled.
- Also accepts a front-panel/programmer byte stream that fills memory sequentially through a valid/ready handshake before the CPU runs.

Parameters:
- AW, 4, address width; matches MAR output width.
- DW, 8, data word width.
- DEPTH, 16, number of words; always 2**AW.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- clr  input  1  asynchronous, active-low reset (clr=0 resets immediately, independent of clk).
- addr  input  AW  address from MAR output.
- ce  input  1  active-low output enable; ce=0 drives read data onto bus.
- bus  output  DW  read data toward the bus; 0 when not enabled.
- prog  input  1  1 selects programming mode, 0 selects run mode.
- pdata  input  DW  programming data word.
- pvalid  input  1  programming word valid.
- pready  output  1  RAM can accept a programming word this cycle.
- pdone  output  1  all DEPTH words written in the current programming session.

Behaviour:
- Reset (clr=0, async):
  - mem[0..DEPTH-1]=0; rdata=0; pptr=0; state=RUN; pready=0; pdone=0; bus=0.
  - Reset mid-programming aborts the session. Words already written are cleared.
- States: RUN, PROG, FULL.
  - RUN -> PROG when prog=1 at a rising edge; pptr<=0 on entry.
  - PROG -> FULL when the write to address DEPTH-1 is accepted.
  - PROG -> RUN when prog=0, including mid-session. Partial contents are kept; the next session restarts at pptr=0.
  - FULL -> RUN when prog=0. FULL holds while prog=1.
- PROG handshake:
  - pready=1 combinationally only in state PROG.
  - Transfer occurs on a rising edge with pvalid=1 and pready=1: mem[pptr]<=pdata, pptr<=pptr+1.
  - pvalid without pready is ignored. pdata may change freely when pvalid=0.
  - pptr does not wrap. A transfer at pptr=DEPTH-1 enters FULL, and no further writes occur.
- pdone: registered; 1 in FULL only.
- Read path (RUN only):
  - Every rising edge, rdata<=mem[addr]. Latency is 1 cycle: an address presented before edge N gives data valid after edge N.
  - bus = (state==RUN && ce==0) ? rdata : 0. This output gating is combinational.
- Read path (PROG/FULL): rdata holds its last value; bus=0 regardless of ce. prog has priority over ce.
- addr changing every cycle gives back-to-back reads with one-cycle latency and no bubbles.
- Memory is written only by the programming handshake. There is no CPU write path in this block.
- Out-of-range addresses cannot occur (AW bits, DEPTH=2**AW).

Test Plan:
1. Reset then RUN, ce=0, addr=4'h5 -> bus=8'h00 after next edge; pready=0, pdone=0.
2. prog=1; stream 16 words 8'h10+i with pvalid held 1 -> one write per cycle. pdone=1 one cycle after the 16th transfer; pready=0 from then; bus=0 throughout.
3. prog=0; ce=0; addr=3 -> bus=8'h13 after one edge. Then addr=4'hF -> 8'h1F. ce=1 -> bus=0 immediately.
4. prog=1; 5 words 8'hA0..8'hA4 with pvalid toggled 1/0 every cycle -> only pvalid-high cycles write. prog=0 mid-session -> mem[0..4]=A0..A4 and mem[5..15] retain 8'h15..8'h1F.
5. prog=1; assert clr=0 between edges after 3 writes -> pready, pdone and bus drop to 0 at once. After release, reading all addresses in RUN returns 8'h00.
6. RUN with ce=0; addr sequence 2,7,2 on consecutive cycles -> bus shows mem[2], mem[7], mem[2], each one cycle after its address.
